// File: rtl/nn_pkg.sv
// Shared fixed-point constants, FSM state encoding and saturating-add helper for the NN datapath.
package nn_pkg;

  localparam int unsigned FRAC_BITS_DEF = 16;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StEmit,
    StDone
  } state_e;

  // Clamps to the 64-bit rails instead of wrapping, so long dot products of large values clip.
  function automatic logic signed [63:0] sat_add64(input logic signed [63:0] a,
                                                   input logic signed [63:0] b);
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
    if (s[64] != s[63]) begin
      sat_add64 = s[64] ? {1'b1, 63'b0} : {1'b0, {63{1'b1}}};
    end else begin
      sat_add64 = s[63:0];
    end
  endfunction

endpackage

// File: rtl/nn_sat_shift.sv
// Combinational rescale of a 64-bit accumulator to 32-bit fixed point with saturation.
// Optional ReLU clamp when LAYER_MAC_RELU_EN is defined.
module nn_sat_shift
  import nn_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [63:0] acc_i,
  output logic        [31:0] res_o
);

  localparam logic signed [63:0] SatHi = {{32{1'b0}}, SAT_MAX};
  localparam logic signed [63:0] SatLo = {{32{1'b1}}, SAT_MIN};

  logic signed [63:0] shifted;
  logic        [31:0] sat;

  always_comb begin
    shifted = acc_i >>> FRAC_BITS;
    if (shifted > SatHi) begin
      sat = SAT_MAX;
    end else if (shifted < SatLo) begin
      sat = SAT_MIN;
    end else begin
      sat = shifted[31:0];
    end
`ifdef LAYER_MAC_RELU_EN
    res_o = sat[31] ? 32'h0000_0000 : sat;
`else
    res_o = sat;
`endif
  end

endmodule

// File: rtl/layer_mac.sv
// Fully-connected layer engine: one MAC per cycle per neuron, results emitted over a
// valid/ready port. ReLU on results is enabled by defining LAYER_MAC_RELU_EN.
module layer_mac
  import nn_pkg::*;
#(
  parameter int unsigned N_IN      = 64,
  parameter int unsigned N_OUT     = 32,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] weight_addr,
  input  logic [31:0] weight_data,
  output logic [15:0] act_addr,
  input  logic [31:0] act_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] NIn     = 16'(N_IN);
  localparam logic [15:0] LastIn  = 16'(N_IN - 1);
  localparam logic [15:0] LastOut = 16'(N_OUT - 1);

  state_e             state_q, state_d;
  logic        [15:0] i_q, i_d, o_q, o_d;
  logic        [15:0] wa_q, wa_d, aa_q, aa_d;
  logic        [15:0] oi_q, oi_d;
  logic        [31:0] od_q, od_d;
  logic signed [63:0] acc_q, acc_d;
  logic signed [63:0] prod, acc_sum;
  logic        [31:0] sat_res;
  logic               last_in, last_out;

  assign last_in  = (i_q == LastIn);
  assign last_out = (o_q == LastOut);
  assign prod     = $signed({{32{weight_data[31]}}, weight_data}) *
                    $signed({{32{act_data[31]}}, act_data});
  assign acc_sum  = sat_add64(acc_q, prod);

  // Final product folds in combinationally so EMIT is entered with the complete sum.
  nn_sat_shift #(
    .FRAC_BITS(FRAC_BITS)
  ) u_sat_shift (
    .acc_i(acc_sum),
    .res_o(sat_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      o_q     <= '0;
      wa_q    <= '0;
      aa_q    <= '0;
      oi_q    <= '0;
      od_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      o_q     <= o_d;
      wa_q    <= wa_d;
      aa_q    <= aa_d;
      oi_q    <= oi_d;
      od_q    <= od_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StMac;
      StMac:   if (last_in) state_d = StEmit;
      StEmit:  if (out_ready) state_d = last_out ? StDone : StMac;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    i_d   = i_q;
    o_d   = o_q;
    wa_d  = wa_q;
    aa_d  = aa_q;
    oi_d  = oi_q;
    od_d  = od_q;
    acc_d = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          i_d   = '0;
          o_d   = '0;
          wa_d  = '0;
          aa_d  = '0;
          acc_d = '0;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        i_d   = last_in ? 16'd0 : i_q + 16'd1;
        aa_d  = i_d;
        wa_d  = o_q * NIn + i_d;
        if (last_in) begin
          od_d = sat_res;
          oi_d = o_q;
        end
      end
      StEmit: begin
        if (out_ready) begin
          o_d   = last_out ? 16'd0 : o_q + 16'd1;
          i_d   = '0;
          aa_d  = '0;
          acc_d = '0;
          wa_d  = o_d * NIn;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StMac:   busy = 1'b1;
      StEmit: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign weight_addr = wa_q;
  assign act_addr    = aa_q;
  assign out_index   = oi_q;
  assign out_data    = od_q;

endmodule

// File: tb/tb_layer_mac.sv
// Directed bench for layer_mac (N_IN=4, N_OUT=2) with a dot-product reference model.
module tb_layer_mac;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int NW    = N_IN * N_OUT;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] weight_addr;
  logic [31:0] weight_data;
  logic [15:0] act_addr;
  logic [31:0] act_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] wmem [NW];
  logic [31:0] amem [N_IN];

  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;

  int          exp_idx [$];
  logic [31:0] exp_dat [$];
  logic [31:0] got [N_OUT];

  always #5 clk = ~clk;

  assign weight_data = (weight_addr < 16'(NW)) ? wmem[weight_addr[2:0]] : 32'h0;
  assign act_data    = (act_addr < 16'(N_IN)) ? amem[act_addr[1:0]] : 32'h0;

  layer_mac #(
    .N_IN (N_IN),
    .N_OUT(N_OUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .act_addr   (act_addr),
    .act_data   (act_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dot product with the running sum clipped to the signed 64-bit range, then rescaled.
  function automatic logic [31:0] model_neuron(input int o);
    logic signed [65:0] acc, p, q, hi, lo;
    logic signed [31:0] w, a;
    logic        [31:0] r;
    hi  = (66'sd1 <<< 63) - 66'sd1;
    lo  = -(66'sd1 <<< 63);
    acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      w   = wmem[o * N_IN + i];
      a   = amem[i];
      p   = w * a;
      acc = acc + p;
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    q = acc >>> 16;
    if (q > 66'sd2147483647) r = 32'h7FFF_FFFF;
    else if (q < -66'sd2147483648) r = 32'h8000_0000;
    else r = q[31:0];
`ifdef LAYER_MAC_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] relu_lit(input logic [31:0] v);
`ifdef LAYER_MAC_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Output-port monitor: hold rules, address range, and scoreboard of emitted results.
  logic        pv_valid = 1'b0;
  logic        pv_hs = 1'b0;
  logic [31:0] pv_data;
  logic [15:0] pv_idx, pv_wa, pv_aa;

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      pv_valid = 1'b0;
    end else begin
      if (pv_valid && !pv_hs) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pv_data);
        check("hold_index", out_index, pv_idx);
        check("hold_waddr", weight_addr, pv_wa);
        check("hold_aaddr", act_addr, pv_aa);
      end
      check("waddr_range", weight_addr < 16'(NW), 1);
      check("aaddr_range", act_addr < 16'(N_IN), 1);
      if (out_valid && out_ready) begin
        if (exp_idx.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result_index", out_index, exp_idx.pop_front());
          check("result_data", out_data, exp_dat.pop_front());
        end
        got[out_index[0]] = out_data;
        hs_count++;
      end
      pv_valid = out_valid;
      pv_hs    = out_valid && out_ready;
      pv_data  = out_data;
      pv_idx   = out_index;
      pv_wa    = weight_addr;
      pv_aa    = act_addr;
    end
  end

  task automatic load_uniform(input logic [31:0] w, input logic [31:0] a);
    for (int j = 0; j < NW; j++) wmem[j] = w;
    for (int i = 0; i < N_IN; i++) amem[i] = a;
  endtask

  // One pass; hold = EMIT cycles with ready low at the first result, spur = cycles to pulse start.
  task automatic run_pass(input string tag, input int hold, input logic [31:0] spur,
                          input int exp_lat);
    int k, held, hs_k, hs_idx;
    bit seen;
    for (int o = 0; o < N_OUT; o++) begin
      exp_idx.push_back(o);
      exp_dat.push_back(model_neuron(o));
    end
    hs_count = 0;
    @(negedge clk);
    #1;
    out_ready = (hold == 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0; held = 0; hs_k = -1; hs_idx = 0; seen = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      #1;
      k++;
      if (hs_k >= 0 && k == hs_k + 1 && hs_idx < N_OUT - 1) begin
        check({tag, "_next_busy"}, busy, 1);
        check({tag, "_next_valid"}, out_valid, 0);
        check({tag, "_next_waddr"}, weight_addr, 16'(N_IN * (hs_idx + 1)));
        check({tag, "_next_aaddr"}, act_addr, 0);
      end
      if (held < hold) begin
        if (out_valid) held++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      start = (k < 32) ? spur[k] : 1'b0;
      if (out_valid && out_ready) begin
        hs_k   = k;
        hs_idx = int'(out_index);
      end
      if (done) seen = 1;
    end
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
    else check({tag, "_done_latency"}, k, exp_lat);
    repeat (2) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      check({tag, "_idle_after"}, {busy, done, out_valid}, 3'b000);
    end
    check({tag, "_result_count"}, hs_count, N_OUT);
    check({tag, "_queue_empty"}, exp_idx.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    load_uniform(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_waddr", weight_addr, 0);
    check("rst_aaddr", act_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle_no_start", busy, 0);

    // 1.0 * 2.0 summed four times -> 8.0
    load_uniform(32'h0001_0000, 32'h0002_0000);
    run_pass("unit", 0, 32'h0, 11);
    check("unit_r0", got[0], 32'h0008_0000);
    check("unit_r1", got[1], 32'h0008_0000);

    load_uniform(32'hFFFF_0000, 32'h0002_0000);
    run_pass("neg", 0, 32'h0, 11);
    check("neg_r0", got[0], relu_lit(32'hFFF8_0000));
    check("neg_r1", got[1], relu_lit(32'hFFF8_0000));

    load_uniform(32'h7FFF_0000, 32'h7FFF_0000);
    run_pass("satp", 0, 32'h0, 11);
    check("satp_r0", got[0], 32'h7FFF_FFFF);
    check("satp_r1", got[1], 32'h7FFF_FFFF);

    load_uniform(32'h8001_0000, 32'h7FFF_0000);
    run_pass("satn", 0, 32'h0, 11);
    check("satn_r0", got[0], relu_lit(32'h8000_0000));
    check("satn_r1", got[1], relu_lit(32'h8000_0000));

    // Distinct weights exercise addressing; ready withheld for five EMIT cycles.
    for (int j = 0; j < NW; j++) wmem[j] = 32'((j + 1) << 16);
    for (int i = 0; i < N_IN; i++) amem[i] = 32'((i + 1) << 16);
    run_pass("stall", 5, 32'h0, 16);
    check("stall_r0", got[0], 32'h001E_0000);
    check("stall_r1", got[1], 32'h0046_0000);

    // Mixed signs; start pulsed in MAC, EMIT and DONE must be ignored.
    amem[0] = 32'h0003_0000;
    amem[1] = 32'hFFFE_0000;
    amem[2] = 32'h0000_8000;
    amem[3] = 32'h0001_0000;
    for (int j = 0; j < NW; j++) begin
      wmem[j] = (j % 2 == 1) ? -32'((j + 1) << 16) : 32'((j + 1) << 16);
    end
    run_pass("spur", 0, (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 11), 11);

    // Reset in the second MAC cycle aborts the pass.
    load_uniform(32'h0001_0000, 32'h0002_0000);
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_waddr", weight_addr, 0);
    check("mid_rst_aaddr", act_addr, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_index", out_index, 0);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", {busy, out_valid, done}, 3'b000);
    end
    run_pass("after_rst", 0, 32'h0, 11);
    check("after_rst_r0", got[0], 32'h0008_0000);
    check("after_rst_r1", got[1], 32'h0008_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_mac.md
LAYER_MAC -- requirements
Module: layer_mac

Interface
REQ-001 SHALL have parameter N_IN, default 64: input vector length, which is also the weight row length.
REQ-002 SHALL have parameter N_OUT, default 32: number of output neurons; N_IN*N_OUT <= 2048.
REQ-003 SHALL have parameter FRAC_BITS, default 16: fractional bits of the signed fixed-point format.
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-high.
REQ-006 SHALL have port start  in  1: one-cycle request to begin a layer pass.
REQ-007 SHALL have port weight_addr  out  16: address to the weight ROM; ROM data returns combinationally in the same cycle.
REQ-008 SHALL have port weight_data  in  32: signed weight.
REQ-009 SHALL have port act_addr  out  16: address to the activation buffer, also combinational-read.
REQ-010 SHALL have port act_data  in  32: signed activation.
REQ-011 SHALL have port out_valid  out  1: a result is presented.
REQ-012 SHALL have port out_ready  in  1: consumer accepts a result.
REQ-013 SHALL have port out_index  out  16: neuron index of the presented result.
REQ-014 SHALL have port out_data  out  32: signed result.
REQ-015 SHALL have port busy  out  1: high from the accepted start until the DONE state.
REQ-016 SHALL have port done  out  1: one-cycle pulse at pass completion.

Function
REQ-017 SHALL implement FSM states IDLE, MAC, EMIT, DONE with transitions: IDLE->MAC on start; MAC->EMIT after N_IN accumulations; EMIT->MAC on handshake when more neurons remain; EMIT->DONE on handshake after the last neuron; DONE->IDLE unconditionally.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL drive weight_addr = o*N_IN + i and act_addr = i from registers, where o is the neuron counter and i the input counter.
REQ-020 SHALL, in each MAC cycle, add the full 64-bit signed product weight_data*act_data into a 64-bit accumulator, then increment i.
REQ-021 SHALL clear the accumulator and i on entry to MAC.
REQ-022 SHALL, on entry to EMIT, register out_data = (acc >>> FRAC_BITS) saturated to [0x80000000, 0x7FFFFFFF], with out_index = o.
REQ-023 SHALL hold out_valid high with out_data, out_index, and both addresses stable until out_valid && out_ready, and SHALL never drop out_valid without a handshake.
REQ-024 SHALL complete a handshake in the first EMIT cycle if out_ready is already high, giving N_IN+1 cycles per neuron and N_OUT*(N_IN+1)+1 cycles from start to done with constant ready.
REQ-025 SHALL wrap i from N_IN-1 to 0 and o from N_OUT-1 to 0; no address SHALL exceed N_IN*N_OUT-1.

Reset
REQ-026 SHALL, on reset (at any time, including mid-pass), force state IDLE, zero the counters, accumulator, weight_addr, act_addr, out_data and out_index, deassert out_valid, busy and done, and discard any partial pass.
REQ-027 SHALL need a fresh start after reset release to run a pass.

Configuration
REQ-028 SHALL, with LAYER_MAC_RELU_EN defined, clamp negative saturated results to 0x00000000 before registering out_data.
REQ-029 SHALL, without LAYER_MAC_RELU_EN, emit the signed saturated result unchanged; timing is identical in both builds.

Structure
REQ-030 SHALL take FRAC_BITS default, the state encoding, and the SAT_MAX/SAT_MIN constants from shared package nn_pkg.
REQ-031 SHALL place shift-and-saturate (plus optional ReLU) in sub-module nn_sat_shift, which is combinational and parameterised by FRAC_BITS.

Verification (N_IN=4, N_OUT=2)
REQ-032 SHALL cover: all weights 0x00010000, all acts 0x00020000, ready high -> results 0x00080000 at indices 0 and 1, done at cycle 11 after start.
REQ-033 SHALL cover: weights 0xFFFF0000, acts 0x00020000 -> 0xFFF80000 without RELU_EN and 0x00000000 with RELU_EN.
REQ-034 SHALL cover: weights and acts 0x7FFF0000 -> out_data 0x7FFFFFFF; negated weights -> 0x80000000 (non-ReLU build).
REQ-035 SHALL cover: out_ready low 5 cycles during first EMIT -> out_valid, out_data, out_index and addresses held stable; neuron 1 starts the cycle after the handshake.
REQ-036 SHALL cover: start pulsed while busy -> ignored, exactly N_OUT results emitted.
REQ-037 SHALL cover: reset asserted at MAC cycle 2 -> all outputs zero immediately, no out_valid; a subsequent start gives a correct full pass.
